// File: rtl/addsub.sv
// BF16 adder/subtractor with round-to-nearest-even, flush-to-zero on subnormal inputs and outputs.
// Combinational datapath into a single output register; one result per accepted operand pair.
module addsub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        operation,
  output logic        out_valid,
  output logic [15:0] result
);

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  bf16_t opa, opb, x, y;
  logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign opa = a;
  assign opb = {b[15] ^ operation, b[14:0]};

  assign a_zero = (opa.exp == 8'h00);
  assign b_zero = (opb.exp == 8'h00);
  assign a_inf  = (opa.exp == 8'hFF) && (opa.frac == 7'd0);
  assign b_inf  = (opb.exp == 8'hFF) && (opb.frac == 7'd0);
  assign a_nan  = (opa.exp == 8'hFF) && (opa.frac != 7'd0);
  assign b_nan  = (opb.exp == 8'hFF) && (opb.frac != 7'd0);

  // X is the larger magnitude; exp-then-frac ordering equals the raw 15-bit compare
  always_comb begin
    if (opa[14:0] >= opb[14:0]) begin
      x = opa;
      y = opb;
    end else begin
      x = opb;
      y = opa;
    end
  end

  logic [7:0]  ediff;
  logic [10:0] xm, ym, yal;
  logic [21:0] ysh;
  logic        eff_sub;
  logic [11:0] sum;

  assign ediff   = x.exp - y.exp;
  assign xm      = {1'b1, x.frac, 3'b000};
  assign ym      = {1'b1, y.frac, 3'b000};
  assign ysh     = {ym, 11'd0} >> ediff[3:0];
  assign yal     = (ediff >= 8'd11) ? 11'd1 : {ysh[21:12], ysh[11] | (|ysh[10:0])};
  assign eff_sub = x.sign ^ y.sign;
  assign sum     = eff_sub ? ({1'b0, xm} - {1'b0, yal}) : ({1'b0, xm} + {1'b0, yal});

  logic [3:0] lz;
  always_comb begin
    lz = 4'd11;
    for (int i = 0; i < 11; i++)
      if (sum[i]) lz = 4'(10 - i);
  end

  logic [10:0]       nm;
  logic signed [9:0] ne;
  always_comb begin
    nm = sum[10:0];
    ne = $signed({2'b00, x.exp});
    if (!eff_sub && sum[11]) begin
      nm = {sum[11:2], sum[1] | sum[0]};
      ne = ne + 10'sd1;
    end else if (eff_sub) begin
      nm = sum[10:0] << lz;
      ne = ne - $signed({6'd0, lz});
    end
  end

  // nm = {hidden, frac[6:0], guard, round, sticky}
  logic              up;
  logic [8:0]        rm;
  logic signed [9:0] re;
  logic [6:0]        rfrac;
  assign up    = nm[2] & (nm[1] | nm[0] | nm[3]);
  assign rm    = {1'b0, nm[10:3]} + {8'd0, up};
  assign re    = rm[8] ? (ne + 10'sd1) : ne;
  assign rfrac = rm[8] ? rm[7:1] : rm[6:0];

  logic [15:0] fin, f;
  always_comb begin
    if (eff_sub && (sum == 12'd0))
      fin = 16'h0000;
    else if (re >= 10'sd255)
      fin = {x.sign, 8'hFF, 7'd0};
    else if (re <= 10'sd0)
      fin = {x.sign, 15'd0};
    else
      fin = {x.sign, re[7:0], rfrac};
  end

  always_comb begin
    if (a_nan || b_nan)
      f = 16'h7FC0;
    else if (a_inf && b_inf)
      f = (opa.sign == opb.sign) ? opa : 16'h7FC0;
    else if (a_inf)
      f = opa;
    else if (b_inf)
      f = opb;
    else if (a_zero && b_zero)
      f = {opa.sign & opb.sign, 15'd0};
    else if (a_zero)
      f = opb;
    else if (b_zero)
      f = opa;
    else
      f = fin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= f;
    end
  end

endmodule

// File: tb/tb_addsub.sv
// Bench for addsub: directed vector table, reset/valid sequences, and random operands
// checked against a real-arithmetic reference rounded to BF16.
module tb_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        operation;
  logic        out_valid;
  logic [15:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  addsub dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .operation(operation), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        op;
    logic [15:0] want;
  } vec_t;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic real to_real(input logic [15:0] x);
    logic [10:0] de;
    de = 11'(int'(x[14:7]) + 896);
    return $bitstoreal({x[15], de, x[6:0], 45'd0});
  endfunction

  // Exact sum in double, then one RNE rounding to 8 significant bits.
  function automatic logic [15:0] ref_addsub(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rop);
    logic [15:0] be;
    logic        an, bn, ai, bi;
    real         r;
    logic [63:0] bits;
    int          e;
    logic [7:0]  m;
    logic [44:0] rem, half;
    be = {rb[15] ^ rop, rb[14:0]};
    an = (&ra[14:7]) && (|ra[6:0]);
    bn = (&be[14:7]) && (|be[6:0]);
    ai = (&ra[14:7]) && (ra[6:0] == 7'd0);
    bi = (&be[14:7]) && (be[6:0] == 7'd0);
    if (an || bn) return 16'h7FC0;
    if (ai && bi) return (ra[15] == be[15]) ? ra : 16'h7FC0;
    if (ai) return ra;
    if (bi) return be;
    if (ra[14:7] == 8'd0 && be[14:7] == 8'd0) return {ra[15] & be[15], 15'd0};
    if (ra[14:7] == 8'd0) return be;
    if (be[14:7] == 8'd0) return ra;
    r = to_real(ra) + to_real(be);
    if (r == 0.0) return 16'h0000;
    bits = $realtobits(r);
    e    = int'(bits[62:52]) - 896;
    m    = {1'b1, bits[51:45]};
    rem  = bits[44:0];
    half = 45'd1 << 44;
    if (rem > half || (rem == half && m[0])) begin
      if (m == 8'hFF) begin
        m = 8'h80;
        e++;
      end else m++;
    end
    if (e >= 255) return {bits[63], 8'hFF, 7'd0};
    if (e <= 0) return {bits[63], 15'd0};
    return {bits[63], 8'(e), m[6:0]};
  endfunction

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic iop);
    @(negedge clk);
    a = ia; b = ib; operation = iop; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] held, ra, rb, want;
    logic        rop;
    logic [7:0]  ex;

    vecs.push_back('{16'h4188, 16'hC188, 1'b1, 16'h4208});
    vecs.push_back('{16'h44BE, 16'h44D6, 1'b0, 16'h454A});
    vecs.push_back('{16'h4380, 16'h4100, 1'b1, 16'h4378});
    vecs.push_back('{16'h3F80, 16'hBF80, 1'b0, 16'h0000});
    vecs.push_back('{16'h3F80, 16'h3B80, 1'b0, 16'h3F80});
    vecs.push_back('{16'h3F81, 16'h3B80, 1'b0, 16'h3F82});
    vecs.push_back('{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80});
    vecs.push_back('{16'h7F80, 16'hFF80, 1'b0, 16'h7FC0});
    vecs.push_back('{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h8000});
    vecs.push_back('{16'h0001, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'h7F80, 16'h7F80, 1'b1, 16'h7FC0});
    vecs.push_back('{16'h3F80, 16'h7F80, 1'b1, 16'hFF80});
    vecs.push_back('{16'h0000, 16'h3F80, 1'b1, 16'hBF80});
    vecs.push_back('{16'h0080, 16'h0081, 1'b1, 16'h8000});
    vecs.push_back('{16'h4000, 16'h3F80, 1'b0, 16'h4040});

    rst_n = 1'b0; in_valid = 1'b0; a = 16'h0; b = 16'h0; operation = 1'b0;
    #2;
    check("reset_result", result, 16'h0000);
    check("reset_valid", {15'd0, out_valid}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].va, vecs[i].vb, vecs[i].op);
      check($sformatf("vec%0d_valid", i), {15'd0, out_valid}, 16'd1);
      check($sformatf("vec%0d_result", i), result, vecs[i].want);
    end

    // in_valid low: result holds, out_valid drops
    held = result;
    @(negedge clk);
    in_valid = 1'b0; a = 16'h4000; b = 16'h4000;
    @(posedge clk); #1;
    check("hold_valid", {15'd0, out_valid}, 16'd0);
    check("hold_result", result, held);

    // async reset mid-stream clears without a clock edge
    issue(16'h4000, 16'h4000, 1'b0);
    check("pre_rst_result", result, 16'h4080);
    @(negedge clk);
    a = 16'h4100; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_result", result, 16'h0000);
    check("async_rst_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;
    check("rst_hold_result", result, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // random back-to-back issue against the reference
    for (int i = 0; i < 1500; i++) begin
      ra  = 16'($urandom);
      rop = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        rb = 16'($urandom);
      end else begin
        ex = ra[14:7] + 8'($urandom_range(3, 0)) - 8'd1;
        rb = {1'($urandom), ex, 7'($urandom)};
      end
      want = ref_addsub(ra, rb, rop);
      issue(ra, rb, rop);
      check($sformatf("rnd%0d_valid", i), {15'd0, out_valid}, 16'd1);
      if (result !== want)
        check($sformatf("rnd%0d %h %s %h", i, ra, rop ? "-" : "+", rb), result, want);
      else
        n_tests++;
    end
    @(negedge clk);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
